// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one pipelined multiplier between NUM_REQ requesters
// MULT_SHARE_FIXED_PRIORITY_EN: pointer pinned at 0, so requester 0 always has highest priority
module mult_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int A_WIDTH      = 16,
  parameter int B_WIDTH      = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int MULT_LATENCY = 2,
  parameter int ID_WIDTH     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [A_WIDTH-1:0]          mult_a,
  output logic [B_WIDTH-1:0]          mult_b,
  input  logic [OUTPUT_WIDTH-1:0]     mult_result,
  output logic                        res_valid,
  output logic [ID_WIDTH-1:0]         res_id,
  output logic [OUTPUT_WIDTH-1:0]     res_data,
  output logic                        busy
);

  localparam int DEPTH = MULT_LATENCY + 1;

  logic [ID_WIDTH-1:0]               ptr_q, ptr_d;
  logic [A_WIDTH-1:0]                mult_a_q, mult_a_d;
  logic [B_WIDTH-1:0]                mult_b_q, mult_b_d;
  logic [DEPTH-1:0]                  tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][ID_WIDTH-1:0]    tag_id_q, tag_id_d;
  logic                              res_valid_q, res_valid_d;
  logic [ID_WIDTH-1:0]               res_id_q, res_id_d;
  logic [OUTPUT_WIDTH-1:0]           res_data_q, res_data_d;

  logic                              found;
  logic                              fire;
  logic [NUM_REQ-1:0]                grant_oh;
  logic [ID_WIDTH-1:0]               cand_id;
  logic [A_WIDTH-1:0]                sel_a;
  logic [B_WIDTH-1:0]                sel_b;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    found    = 1'b0;
    grant_oh = '0;
    cand_id  = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (i == (int'(ptr_q) + k) % NUM_REQ)) begin
          found       = 1'b1;
          grant_oh[i] = 1'b1;
          cand_id     = ID_WIDTH'(i);
          sel_a       = req_a[i*A_WIDTH +: A_WIDTH];
          sel_b       = req_b[i*B_WIDTH +: B_WIDTH];
        end
      end
    end
  end

  assign fire      = enable & reset & found;
  assign req_ready = fire ? grant_oh : '0;

  always_comb begin
    ptr_d    = ptr_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    if (fire) begin
`ifdef MULT_SHARE_FIXED_PRIORITY_EN
      ptr_d = '0;
`else
      ptr_d = (cand_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : cand_id + ID_WIDTH'(1);
`endif
      mult_a_d = sel_a;
      mult_b_d = sel_b;
    end

    // Tags advance every cycle; a non-grant cycle inserts a bubble.
    tag_vld_d = {tag_vld_q[DEPTH-2:0], fire};
    tag_id_d  = {tag_id_q[DEPTH-2:0], cand_id};

    res_valid_d = tag_vld_q[DEPTH-1];
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    if (tag_vld_q[DEPTH-1]) begin
      res_id_d   = tag_id_q[DEPTH-1];
      res_data_d = mult_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q       <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign busy      = (|tag_vld_q) | res_valid_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter with a signed two-stage multiplier model
module tb_mult_share_arbiter;

  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int BW  = 16;
  localparam int OW  = 16;
  localparam int ML  = 2;
  localparam int IW  = 2;
  localparam int LAT = ML + 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   mult_a;
  logic [BW-1:0]   mult_b;
  logic [OW-1:0]   mult_result;
  logic            res_valid;
  logic [IW-1:0]   res_id;
  logic [OW-1:0]   res_data;
  logic            busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .OUTPUT_WIDTH(OW),
    .MULT_LATENCY(ML), .ID_WIDTH(IW)
  ) u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mult_a(mult_a), .mult_b(mult_b), .mult_result(mult_result),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  // Q4 x Q4 -> Q8: the low 16 bits of the signed product are the result.
  function automatic logic [OW-1:0] prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[OW-1:0];
  endfunction

  logic [OW-1:0] mult_p1;
  always @(posedge clk) begin
    mult_p1     <= prod(mult_a, mult_b);
    mult_result <= mult_p1;
  end

  typedef struct {
    int            id;
    logic [OW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    logic          en;
    logic [N-1:0]  v;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [N-1:0]  rdy;
  } vec_t;

  exp_t          sbq[$];
  vec_t          tbl[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            m_ptr = 0;
  int            last_g = -1;
  logic [OW-1:0] m_last = '0;
  logic [AW-1:0] m_ma = '0;
  logic [BW-1:0] m_mb = '0;
  logic [AW-1:0] op_a[N];
  logic [BW-1:0] op_b[N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic void add(input logic en, input logic [N-1:0] v, input logic [AW-1:0] a,
                              input logic [BW-1:0] b, input logic [N-1:0] rdy);
    vec_t r;
    r.en = en; r.v = v; r.a = a; r.b = b; r.rdy = rdy;
    tbl.push_back(r);
  endfunction

  task automatic tick(input bit use_tbl, input logic [N-1:0] tbl_rdy);
    int            g;
    int            idx;
    logic [1:0]    gi;
    logic [N-1:0]  exp_rdy;
    logic          exp_busy;
    exp_t          e;
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = op_a[i];
      req_b[i*BW +: BW] = op_b[i];
    end
    @(negedge clk);
    g = -1;
    if (enable && reset) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && ((req_valid >> idx) & N'(1)) != '0) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    gi = g[1:0];
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (use_tbl) chk("tbl_ready", 32'(req_ready), 32'(tbl_rdy));
    chk("mult_a", 32'(mult_a), 32'(m_ma));
    chk("mult_b", 32'(mult_b), 32'(m_mb));
    exp_busy = (sbq.size() > 0);
    chk("busy", 32'(busy), 32'(exp_busy));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_id", 32'(res_id), 32'(e.id));
      chk("res_data", 32'(res_data), 32'(e.data));
      m_last = e.data;
    end else begin
      chk("res_valid_idle", 32'(res_valid), 32'd0);
      chk("res_data_hold", 32'(res_data), 32'(m_last));
    end
    last_g = g;
    if (!reset) begin
      sbq.delete();
      m_ptr  = 0;
      m_last = '0;
      m_ma   = '0;
      m_mb   = '0;
    end else if (g >= 0) begin
      e.id   = g;
      e.data = prod(op_a[gi], op_b[gi]);
      e.due  = cyc + LAT;
      sbq.push_back(e);
      m_ma = op_a[gi];
      m_mb = op_b[gi];
`ifdef MULT_SHARE_FIXED_PRIORITY_EN
      m_ptr = 0;
`else
      m_ptr = (g + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef MULT_SHARE_FIXED_PRIORITY_EN
    for (int r = 0; r < 6; r++) add(1'b1, 4'b0011, 16'h0010 + 16'(r), 16'h0020, 4'b0001);
    add(1'b1, 4'b0010, 16'h0030, 16'h0011, 4'b0010);
    add(1'b1, 4'b0011, 16'h0044, 16'hfff0, 4'b0001);
    for (int r = 0; r < 4; r++) add(1'b1, 4'b0000, 16'h0000, 16'h0000, 4'b0000);
`else
    add(1'b1, 4'b0000, 16'h0000, 16'h0000, 4'b0000);
    add(1'b1, 4'b0010, 16'h0010, 16'h0020, 4'b0010);
    for (int r = 0; r < 4; r++) add(1'b1, 4'b0000, 16'h0000, 16'h0000, 4'b0000);
    add(1'b1, 4'b1000, 16'h0025, 16'h0013, 4'b1000);
    for (int r = 0; r < 2; r++) begin
      add(1'b1, 4'b1111, 16'h0031 + 16'(r), 16'h0047, 4'b0001);
      add(1'b1, 4'b1111, 16'h0052, 16'hffa0 + 16'(r), 4'b0010);
      add(1'b1, 4'b1111, 16'h8001, 16'h0063, 4'b0100);
      add(1'b1, 4'b1111, 16'h7fff, 16'h7fff, 4'b1000);
    end
    add(1'b1, 4'b0100, 16'h0018, 16'h0022, 4'b0100);
    add(1'b1, 4'b0101, 16'h0019, 16'h0023, 4'b0001);
    add(1'b1, 4'b0101, 16'h001a, 16'h0024, 4'b0100);
    add(1'b1, 4'b0101, 16'h001b, 16'h0025, 4'b0001);
    add(1'b1, 4'b0101, 16'h0040, 16'h0040, 4'b0100);
    add(1'b1, 4'b1000, 16'h0041, 16'h0041, 4'b1000);
    for (int r = 0; r < 6; r++) add(1'b0, 4'b1001, 16'h0042, 16'h0042, 4'b0000);
    add(1'b1, 4'b1001, 16'h0042, 16'h0042, 4'b0001);
    for (int r = 0; r < 5; r++) add(1'b1, 4'b0000, 16'h0000, 16'h0000, 4'b0000);
`endif

    foreach (tbl[r]) begin
      enable    = tbl[r].en;
      req_valid = tbl[r].v;
      for (int i = 0; i < N; i++) begin
        op_a[i] = tbl[r].a + AW'(16 * i) - 16'h0010;
        op_b[i] = tbl[r].b + BW'(257 * i) - 16'h0101;
      end
      tick(1'b1, tbl[r].rdy);
    end

    // Reset two cycles after a grant: the op must vanish.
    enable    = 1'b1;
    req_valid = 4'b0001;
    op_a[0]   = 16'h0123;
    op_b[0]   = 16'h0045;
    tick(1'b0, '0);
    req_valid = '0;
    tick(1'b0, '0);
    reset = 1'b0;
    tick(1'b0, '0);
    reset     = 1'b1;
    req_valid = 4'b0110;
    tick(1'b1, 4'b0010);
    req_valid = '0;
    repeat (6) tick(1'b0, '0);

    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_g != i)) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          op_a[i]      = AW'($urandom);
          op_b[i]      = BW'($urandom);
        end
      end
      enable = ($urandom_range(0, 7) != 0);
      reset  = ($urandom_range(0, 39) != 0);
      tick(1'b0, '0);
    end

    reset     = 1'b1;
    enable    = 1'b1;
    req_valid = '0;
    repeat (6) tick(1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one external pipelined fractional multiplier (FRAC_BITS-shifted result, fixed latency) between NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake on the request side; one operand pair is issued per cycle at most.
- A tag pipeline tracks in-flight operations, so every result returns with the id of the requester that issued it.
- Sits between the filter/PID blocks and a single clocked multiplier instance, saving DSP blocks.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- A_WIDTH, 16, operand A width per requester
- B_WIDTH, 16, operand B width per requester
- OUTPUT_WIDTH, 16, multiplier result width
- MULT_LATENCY, 2, clock edges from multiplier operand sample to mult_result valid; must match the instance (2 signed, 1 unsigned)
- ID_WIDTH, 2, width of the requester id; must be >= clog2(NUM_REQ)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- enable  in  1  1 = grants allowed; 0 = no new grants, in-flight ops drain
- req_valid  in  NUM_REQ  per-requester operand valid
- req_a  in  NUM_REQ*A_WIDTH  packed operand A; requester i occupies [i*A_WIDTH +: A_WIDTH]
- req_b  in  NUM_REQ*B_WIDTH  packed operand B; same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid, enable and pointer
- mult_a  out  A_WIDTH  registered operand A to multiplier
- mult_b  out  B_WIDTH  registered operand B to multiplier
- mult_result  in  OUTPUT_WIDTH  multiplier output
- res_valid  out  1  one-cycle pulse per completed op
- res_id  out  ID_WIDTH  requester owning res_data
- res_data  out  OUTPUT_WIDTH  result
- busy  out  1  1 while any op is in flight

Behaviour:
- Reset (reset==0 at a clk edge):
  - rr pointer = 0.
  - mult_a, mult_b, res_data = 0; res_valid = 0; res_id = 0; busy = 0.
  - Tag pipeline cleared.
  - Reset mid-operation discards every in-flight op; no res_valid pulse for them, ever.
- Arbitration:
  - Candidate = first i with req_valid[i], searching i = ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[i] = enable & reset & (i == candidate).
  - req_ready is all-zero when enable=0, when reset=0, or when no request is valid.
- Handshake: req_valid[i] & req_ready[i] in cycle n.
  - At the edge ending cycle n: mult_a/mult_b <= requester i's operands; tag {1, i} enters stage 0; ptr <= (i+1) mod NUM_REQ.
  - Requesters must hold operands stable while valid and not ready.
- No grant in a cycle: mult_a/mult_b hold their value, a {0,x} bubble enters the tag pipeline, ptr is unchanged.
- Tag pipeline depth MULT_LATENCY+1, advancing every cycle; there is no stall.
- Latency: an op accepted in cycle n has mult_a/mult_b valid in cycle n+1 and mult_result valid in cycle n+1+MULT_LATENCY.
  - At the end of that cycle res_data <= mult_result and res_id <= tag id; res_valid=1 during cycle n+2+MULT_LATENCY (n+4 at the default).
- Throughput: 1 op/cycle sustained; back-to-back results on consecutive cycles are legal.
- No output back-pressure: consumers must accept res_valid whenever it pulses.
- res_data keeps its last value while res_valid=0.
- busy = OR of all tag valid bits plus the output stage.
- enable falling mid-stream: the grant in the cycle enable drops is suppressed (combinational); queued ops still complete with the original timing.
- Widths are passed straight through; the arbiter does no arithmetic on data.

Optional Feature:
- Macro MULT_SHARE_FIXED_PRIORITY_EN.
  - Defined: ptr stays at 0 permanently, so the lowest valid index always wins (requester 0 highest priority); starvation is possible and accepted.
  - Undefined: round-robin as described.

Test Plan:
- Single op, defaults, signed multiplier, FRAC A/B=4, OUT=8.
  - Stimulus: requester 1 valid in cycle 5 with a=0x0010 (1.0), b=0x0020 (2.0).
  - Required: req_ready=4'b0010 in cycle 5; res_valid only in cycle 9, res_id=1, res_data=0x0200; busy high cycles 6-9.
- Round-robin fairness.
  - Stimulus: all four requesters held valid for 8 cycles.
  - Required: grants 0,1,2,3,0,1,2,3; res_valid 8 consecutive cycles with res_id 0,1,2,3,0,1,2,3 in that order; each result equals its requester's product.
- Wrap and skip.
  - Stimulus: ptr=3 (last grant 2), only requesters 0 and 2 valid.
  - Required: grant 0 then 2 then 0.
- Enable gating.
  - Stimulus: enable=0 while requesters 0 and 3 are valid, two ops already in flight.
  - Required: req_ready=0 throughout; the two in-flight results still appear at n+4; busy=0 afterwards; after enable=1 the next grant honours ptr.
- Reset mid-op.
  - Stimulus: reset=0 for 1 cycle, 2 cycles after a grant.
  - Required: no res_valid for that op; all outputs 0, busy=0; next grant after reset goes to the lowest valid index.
- With MULT_SHARE_FIXED_PRIORITY_EN.
  - Stimulus: requesters 0 and 1 valid continuously.
  - Required: requester 0 granted every cycle; requester 1 never granted.
